vmx_cmd_decoder: RTL
====================

# vmx_cmd_decoder

Command front-end of the VMX engine. Consumes the 32-bit AXI-Stream control channel from the PS, frames each header word and its argument words into a complete command, and queues the commands in a small FIFO. The access processor (LOAD/STORE) and the execute processor (EXEC) draw commands from this queue through a valid/ready handshake. Framing and opcode errors are reported as sticky flags to the AXI-Lite flag register block.

## Interface
- `DATA_WIDTH`, 32: stream word width. Only 32 is supported.
- `FIFO_DEPTH`, 4: number of command entries; power of two, ≥2.
- `aclk` in 1: sole clock.
- `areset` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in 32: command word.
- `s_axis_tvalid` in 1: word valid.
- `s_axis_tlast` in 1: last word of a command.
- `s_axis_tready` out 1: word accepted when `tvalid && tready`.
- `cmd_valid` out 1: head entry of the FIFO is valid.
- `cmd_ready` in 1: consumer pops the head entry when `cmd_valid && cmd_ready`.
- `cmd_opcode` out 4: opcode of the head entry.
- `cmd_tag` out 16: tag of the head entry.
- `cmd_arg0` out 32: first argument; 0 if the command has no arguments.
- `cmd_arg1` out 32: second argument; 0 if unused.
- `err_clr` in 1: single-cycle pulse that clears both error flags.
- `err_illegal` out 1: sticky flag; an unknown opcode was received.
- `err_framing` out 1: sticky flag; `tlast` arrived at the wrong position.
- `cmd_count` out 16: number of commands pushed since reset, wrapping.

## Operation
- Header word layout: [31:28] opcode, [27:16] reserved (ignored), [15:0] tag.
- Opcodes and argument counts:
  - NOP = 0x0, 0 arguments.
  - LOAD = 0x1, 2 arguments (arg0 = DDR source, arg1 = local destination).
  - STORE = 0x2, 2 arguments (arg0 = local source, arg1 = DDR destination).
  - EXEC = 0x3, 1 argument (config word).
- FSM states:
  - HDR: on accept, latch opcode and tag. A legal opcode with 0 arguments → push, stay in HDR. A legal opcode with >0 arguments → ARG0. An illegal opcode → set `err_illegal`, go to DRAIN (or stay in HDR if `tlast` is high on that word).
  - ARG0: on accept, latch arg0. EXEC → push, go to HDR. LOAD/STORE → ARG1.
  - ARG1: on accept, latch arg1, push, go to HDR.
  - DRAIN: discard accepted words until a word with `tlast` is accepted, then go to HDR.
- Framing check:
  - `tlast` high on any word before the final word of a command → set `err_framing`, discard the partial command, go to HDR.
  - `tlast` low on the final word → set `err_framing`, push the command anyway, go to DRAIN.
- NOP commands are pushed and popped like any other command; the consumer discards them.
- `s_axis_tready = !fifo_full`, registered-derived, with no combinational path from `cmd_ready`.
- `cmd_count` increments once per push and wraps from 0xFFFF to 0.
- Error flags: a set condition wins over `err_clr` in the same cycle.

## Timing
- Reset values:
  - `s_axis_tready` = 1.
  - `cmd_valid` = 0.
  - `cmd_*` fields = 0.
  - Both error flags = 0.
  - `cmd_count` = 0.
  - FSM in HDR; FIFO empty.
- Latency: `cmd_valid` rises on the cycle after the final word is accepted (one register stage). The FIFO is first-word-fall-through.
- Full: `tready` falls on the cycle after the push that fills the FIFO. It rises on the cycle after the first pop.
- A simultaneous push and pop when not full leaves occupancy unchanged.
- `tready` keeps the FIFO from overflowing. The FIFO pointers wrap modulo `FIFO_DEPTH`.
- `cmd_*` fields are held stable while `cmd_valid && !cmd_ready`.
- Reset mid-command discards the partial command and the FIFO contents; the FSM returns to HDR.
- Full throughput: one stream word per cycle while the FIFO is not full.

## Configuration
- `VMX_CMD_TLAST_CHECK_EN` defined:
  - The framing check and DRAIN behave as described in Operation.
  - An illegal opcode drains to `tlast`.
- Not defined:
  - `tlast` is ignored.
  - `err_framing` is tied to 0.
  - An illegal opcode discards only the header word; the FSM stays in HDR and there is no DRAIN state.

## Structure
- Package `vmx_pkg` holds:
  - The opcode enum (NOP/LOAD/STORE/EXEC).
  - Header field bit positions.
  - The argument-count function.
  - The `vmx_cmd_t` struct {opcode, tag, arg0, arg1}.
  - The decoder state enum.
- Sub-module `vmx_cmd_fifo`: synchronous FWFT FIFO of `vmx_cmd_t`, parameterised by depth, with full/empty flags.

## Test plan
- Stream LOAD with tag 0x0005, arg0 0x1000_0000, arg1 0x40, `tlast` on arg1 → one command: opcode 1, tag 5, args as sent; `cmd_valid` high 1 cycle after the arg1 accept; `cmd_count` = 1.
- Push 5 EXEC commands with `cmd_ready` = 0 and `FIFO_DEPTH` = 4 → `tready` low after the 4th command; after one pop, the 5th is accepted; commands come out in order.
- Header with opcode 0x7 followed by 2 words, `tlast` on the 3rd, then NOP → `err_illegal` = 1; only the NOP is queued; `err_clr` returns the flag to 0.
- STORE with `tlast` on arg0, then EXEC → `err_framing` = 1; the STORE is dropped and the EXEC is queued intact. With the macro undefined: no error, and the STORE completes with the following word (EXEC header) as arg1.
- Assert `areset` after the ARG0 word of a LOAD → all outputs at reset values; a following NOP is decoded correctly.
- Back-to-back NOPs, 8 cycles, `cmd_ready` = 1 → one command per cycle, `tready` constantly high, `cmd_count` = 8.

Source files
------------

// File: rtl/vmx_pkg.sv
// vmx_pkg: shared types for the VMX command front-end.
//   - vmx_opcode_e     : command opcodes (NOP/LOAD/STORE/EXEC)
//   - header field bit positions
//   - op_is_legal()    : opcode legality
//   - op_arg_count()   : number of argument words that follow a header
//   - vmx_cmd_t        : one framed command as held in the command FIFO
//   - vmx_dec_state_e  : decoder FSM state encoding
package vmx_pkg;

  // Header word layout: [31:28] opcode, [27:16] reserved, [15:0] tag.
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned TAG_MSB = 15;
  localparam int unsigned TAG_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_EXEC  = 4'h3
  } vmx_opcode_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] tag;
    logic [31:0] arg0;
    logic [31:0] arg1;
  } vmx_cmd_t;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_ARG0  = 2'd1,
    ST_ARG1  = 2'd2,
    ST_DRAIN = 2'd3
  } vmx_dec_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= 4'(OP_EXEC);
  endfunction

  function automatic logic [1:0] op_arg_count(input logic [3:0] op);
    case (op)
      4'(OP_LOAD), 4'(OP_STORE): return 2'd2;
      4'(OP_EXEC):               return 2'd1;
      default:                   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vmx_cmd_fifo.sv
// vmx_cmd_fifo: synchronous first-word-fall-through FIFO of vmx_cmd_t.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i        : write wdata_i (ignored when full)
//   wdata_i       : command to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry, valid whenever empty_o is low
//   full_o/empty_o: occupancy flags, derived from a registered count
module vmx_cmd_fifo
  import vmx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  vmx_cmd_t wdata_i,
  input  logic     pop_i,
  output vmx_cmd_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  vmx_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/vmx_cmd_decoder.sv
// vmx_cmd_decoder: frames the 32-bit AXI-Stream control channel into
// commands (header + 0..2 argument words) and queues them in vmx_cmd_fifo.
// Optional feature macro: VMX_CMD_TLAST_CHECK_EN (tlast framing check and
// DRAIN state). Without it tlast is ignored and err_framing stays 0.
// Ports:
//   aclk, areset                 : clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast    : command word stream in
//   s_axis_tready                : high while the command FIFO is not full
//   cmd_valid/cmd_ready          : head-of-queue handshake
//   cmd_opcode/tag/arg0/arg1     : head command fields (0 while empty)
//   err_clr                      : pulse clearing both sticky error flags
//   err_illegal, err_framing     : sticky error flags
//   cmd_count                    : wrapping count of pushed commands
//   dbg_state                    : decoder FSM state (vmx_dec_state_e)
// Handshake: a word/command transfers on a clock edge where valid and ready
// are both high; valid never waits on ready, and tready depends only on
// registered FIFO occupancy (no path from cmd_ready).
module vmx_cmd_decoder
  import vmx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [3:0]            cmd_opcode,
  output logic [15:0]           cmd_tag,
  output logic [31:0]           cmd_arg0,
  output logic [31:0]           cmd_arg1,
  input  logic                  err_clr,
  output logic                  err_illegal,
  output logic                  err_framing,
  output logic [15:0]           cmd_count,
  output logic [1:0]            dbg_state
);

  vmx_dec_state_e state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] tag_q;
  logic [31:0] arg0_q;
  logic        err_illegal_q, err_framing_q;
  logic [15:0] count_q;

  logic        accept, fifo_full, fifo_empty;
  logic [3:0]  hdr_op;
  logic [15:0] hdr_tag;
  logic        push, set_illegal, set_framing, latch_hdr, latch_arg0;
  vmx_cmd_t    push_cmd, head_cmd;

  // last_early  : tlast on a word that is not the command's final word
  // last_missing: final word of a command arrived without tlast
  logic last_early, last_missing, illegal_drain, drain_done;

`ifdef VMX_CMD_TLAST_CHECK_EN
  assign last_early    = s_axis_tlast;
  assign last_missing  = !s_axis_tlast;
  assign illegal_drain = !s_axis_tlast;
  assign drain_done    = s_axis_tlast;
`else
  logic unused_tlast;
  assign unused_tlast  = s_axis_tlast;
  assign last_early    = 1'b0;
  assign last_missing  = 1'b0;
  assign illegal_drain = 1'b0;
  assign drain_done    = 1'b1;
`endif

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign hdr_op  = s_axis_tdata[OPC_MSB:OPC_LSB];
  assign hdr_tag = s_axis_tdata[TAG_MSB:TAG_LSB];

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_HDR;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        ST_HDR: begin
          if (!op_is_legal(hdr_op))           state_d = illegal_drain ? ST_DRAIN : ST_HDR;
          else if (op_arg_count(hdr_op) == 0) state_d = last_missing ? ST_DRAIN : ST_HDR;
          else                                state_d = last_early ? ST_HDR : ST_ARG0;
        end
        ST_ARG0: begin
          if (op_q == 4'(OP_EXEC)) state_d = last_missing ? ST_DRAIN : ST_HDR;
          else                     state_d = last_early ? ST_HDR : ST_ARG1;
        end
        ST_ARG1:  state_d = last_missing ? ST_DRAIN : ST_HDR;
        default:  state_d = drain_done ? ST_HDR : ST_DRAIN;
      endcase
    end
  end

  // Output logic: push strobes, error set strobes and field latch enables
  always_comb begin
    push        = 1'b0;
    push_cmd    = '0;
    set_illegal = 1'b0;
    set_framing = 1'b0;
    latch_hdr   = 1'b0;
    latch_arg0  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_HDR: begin
          latch_hdr = 1'b1;
          if (!op_is_legal(hdr_op)) begin
            set_illegal = 1'b1;
          end else if (op_arg_count(hdr_op) == 0) begin
            push            = 1'b1;
            push_cmd.opcode = hdr_op;
            push_cmd.tag    = hdr_tag;
            set_framing     = last_missing;
          end else begin
            set_framing = last_early;
          end
        end
        ST_ARG0: begin
          latch_arg0 = 1'b1;
          if (op_q == 4'(OP_EXEC)) begin
            push            = 1'b1;
            push_cmd.opcode = op_q;
            push_cmd.tag    = tag_q;
            push_cmd.arg0   = s_axis_tdata;
            set_framing     = last_missing;
          end else begin
            set_framing = last_early;
          end
        end
        ST_ARG1: begin
          push            = 1'b1;
          push_cmd.opcode = op_q;
          push_cmd.tag    = tag_q;
          push_cmd.arg0   = arg0_q;
          push_cmd.arg1   = s_axis_tdata;
          set_framing     = last_missing;
        end
        default: ;
      endcase
    end
  end

  // Partial-command fields and status registers. A set strobe wins over
  // err_clr in the same cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      op_q          <= '0;
      tag_q         <= '0;
      arg0_q        <= '0;
      err_illegal_q <= 1'b0;
      err_framing_q <= 1'b0;
      count_q       <= '0;
    end else begin
      if (latch_hdr) begin
        op_q  <= hdr_op;
        tag_q <= hdr_tag;
      end
      if (latch_arg0) arg0_q <= s_axis_tdata;
      if (set_illegal)  err_illegal_q <= 1'b1;
      else if (err_clr) err_illegal_q <= 1'b0;
      if (set_framing)  err_framing_q <= 1'b1;
      else if (err_clr) err_framing_q <= 1'b0;
      // A push always lands: words are only accepted while the FIFO has room.
      if (push) count_q <= count_q + 16'd1;
    end
  end

  vmx_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push),
    .wdata_i (push_cmd),
    .pop_i   (cmd_ready),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s_axis_tready = !fifo_full;
  assign cmd_valid     = !fifo_empty;
  // Fields read as 0 while the queue is empty, so reset values are defined
  // without resetting the FIFO storage.
  assign cmd_opcode    = cmd_valid ? head_cmd.opcode : '0;
  assign cmd_tag       = cmd_valid ? head_cmd.tag    : '0;
  assign cmd_arg0      = cmd_valid ? head_cmd.arg0   : '0;
  assign cmd_arg1      = cmd_valid ? head_cmd.arg1   : '0;
  assign err_illegal   = err_illegal_q;
  assign err_framing   = err_framing_q;
  assign cmd_count     = count_q;
  assign dbg_state     = state_q;

endmodule
